// File: rtl/pydpi_call_arbiter.sv
// pydpi_call_arbiter: round-robin arbiter/sequencer sharing one DPI-backed model among NUM_REQ requesters
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_req_valid/i_req_data     per-requester call request and argument (slice i = [i*DATA_W +: DATA_W])
//   o_req_ready                one-hot accept pulse, combinational in IDLE
//   o_rsp_valid/o_rsp_data     one-hot response pulse to the call owner, with result
//   o_rsp_err                  timeout flag, qualified by o_rsp_valid
//   o_mdl_start/o_mdl_arg      call strobe and held argument to the model
//   i_mdl_done/i_mdl_result    model completion strobe and result
//   o_busy, o_cur_owner        call in flight, and its owner index
module pydpi_call_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int OWN_W   = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_err,
    output logic                      o_mdl_start,
    output logic [DATA_W-1:0]         o_mdl_arg,
    input  logic                      i_mdl_done,
    input  logic [DATA_W-1:0]         i_mdl_result,
    output logic                      o_busy,
    output logic [OWN_W-1:0]          o_cur_owner
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [OWN_W-1:0]    r_last;
    logic [OWN_W-1:0]    r_owner;
    logic [DATA_W-1:0]   r_arg;
    logic [DATA_W-1:0]   r_data;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_found;
    logic [OWN_W-1:0]    w_grant;
    logic [OWN_W-1:0]    w_idx;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_grant_data;

    // Scan downward from the farthest candidate so the nearest one after r_last overwrites and wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = OWN_W'((int'(r_last) + k) % NUM_REQ);
            if (i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_grant_data = i_req_data[int'(w_grant)*DATA_W +: DATA_W];
    assign w_timeout    = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = w_found ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (i_mdl_done || w_timeout) ? S_RESP : S_WAIT;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last  <= OWN_W'(NUM_REQ - 1);
            r_owner <= '0;
            r_arg   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_arg   <= w_grant_data;
                        r_owner <= w_grant;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // done takes precedence over a coincident timeout
                    if (i_mdl_done) begin
                        r_data <= i_mdl_result;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: r_last <= r_owner;
                default: r_cnt <= '0;
            endcase
        end
    end

    // Reset forces the state to IDLE, so the accept pulse is also gated by reset to keep it low while held.
    assign o_req_ready = (i_rst_n && r_state == S_IDLE && w_found) ? NUM_REQ'(1) << w_grant : '0;
    assign o_rsp_valid = (r_state == S_RESP) ? NUM_REQ'(1) << r_owner : '0;
    assign o_rsp_data  = r_data;
    assign o_rsp_err   = r_err;
    assign o_mdl_start = (r_state == S_ISSUE);
    assign o_mdl_arg   = r_arg;
    assign o_busy      = (r_state != S_IDLE);
    assign o_cur_owner = r_owner;
endmodule

// File: tb/tb_pydpi_call_arbiter.sv
// tb_pydpi_call_arbiter: directed and randomized self-checking bench for pydpi_call_arbiter
// Ports: none (top-level bench); drives the DUT clock, reset, requests and model handshake.
module tb_pydpi_call_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic             mdl_start;
    logic [DW-1:0]    mdl_arg;
    logic             mdl_done;
    logic [DW-1:0]    mdl_result;
    logic             busy;
    logic [1:0]       cur_owner;

    logic [DW-1:0]    d [NR];
    int               last;
    int               n_tests = 0;
    int               n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = d[i];
    end

    pydpi_call_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req_valid(req_valid),
        .i_req_data(req_data),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data),
        .o_rsp_err(rsp_err),
        .o_mdl_start(mdl_start),
        .o_mdl_arg(mdl_arg),
        .i_mdl_done(mdl_done),
        .i_mdl_result(mdl_result),
        .o_busy(busy),
        .o_cur_owner(cur_owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_start"}, 64'(mdl_start), 64'd0);
        chk({tag, "_arg"}, 64'(mdl_arg), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_owner"}, 64'(cur_owner), 64'd0);
    endtask

    // One complete call, entered at posedge+1 of an IDLE cycle with at least one request pending.
    // dly in 1..TO: done arrives dly cycles after start; any other value: the model never answers.
    task automatic serve(input int dly, input logic [DW-1:0] res);
        int g;
        int nw;
        bit to;
        logic [DW-1:0] a;
        g = -1;
        for (int k = 1; k <= NR; k++)
            if (g < 0 && req_valid[(last + k) % NR]) g = (last + k) % NR;
        if (g < 0) return;
        @(negedge clk);
        chk("ready", 64'(req_ready), 64'd1 << g);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("start_idle", 64'(mdl_start), 64'd0);
        a = d[g];
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        @(negedge clk);
        chk("start", 64'(mdl_start), 64'd1);
        chk("arg", 64'(mdl_arg), 64'(a));
        chk("owner", 64'(cur_owner), 64'(g));
        chk("busy_issue", 64'(busy), 64'd1);
        chk("ready_issue", 64'(req_ready), 64'd0);
        to = !(dly >= 1 && dly <= TO);
        nw = to ? TO : dly;
        for (int w = 0; w < nw; w++) begin
            @(posedge clk); #1;
            mdl_done   = !to && (w == dly - 1);
            mdl_result = mdl_done ? res : $urandom;
            @(negedge clk);
            chk("rsp_wait", 64'(rsp_valid), 64'd0);
            chk("start_wait", 64'(mdl_start), 64'd0);
            chk("busy_wait", 64'(busy), 64'd1);
            chk("arg_hold", 64'(mdl_arg), 64'(a));
        end
        @(posedge clk); #1;
        mdl_done   = 1'($urandom_range(0, 1));
        mdl_result = $urandom;
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'd1 << g);
        chk("rsp_data", 64'(rsp_data), to ? 64'd0 : 64'(res));
        chk("rsp_err", 64'(rsp_err), 64'(to));
        chk("busy_resp", 64'(busy), 64'd1);
        last = g;
        @(posedge clk); #1;
        mdl_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_n      = 1'b0;
        req_valid  = '0;
        mdl_done   = 1'b0;
        mdl_result = '0;
        for (int i = 0; i < NR; i++) d[i] = '0;
        last = NR - 1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        req_valid = 4'b0001;
        d[0] = 32'h1234;
        serve(3, 32'h5678);

        rst_n = 1'b0;
        #2;
        chk_reset("reset2");
        @(posedge clk); #1;
        rst_n = 1'b1;
        last = NR - 1;
        for (int i = 0; i < NR; i++) d[i] = $urandom;
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            serve(1, $urandom);
            if (n < 4) begin
                req_valid[last] = 1'b1;
                d[last] = $urandom;
            end
        end
        repeat (3) serve(1, $urandom);

        req_valid[2] = 1'b1;
        d[2] = $urandom;
        serve(2, $urandom);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        d[0] = $urandom;
        d[3] = $urandom;
        serve(1, $urandom);
        serve(1, $urandom);

        req_valid[1] = 1'b1;
        d[1] = $urandom;
        serve(0, $urandom);
        req_valid[2] = 1'b1;
        d[2] = $urandom;
        serve(2, 32'hA5A5_0F0F);

        repeat (3) begin
            mdl_done   = 1'b1;
            mdl_result = $urandom;
            @(negedge clk);
            chk("spur_rsp", 64'(rsp_valid), 64'd0);
            chk("spur_busy", 64'(busy), 64'd0);
            chk("spur_start", 64'(mdl_start), 64'd0);
            @(posedge clk); #1;
            mdl_done = 1'b0;
        end
        @(negedge clk);
        chk("spur_after", 64'(busy), 64'd0);
        @(posedge clk); #1;

        req_valid[3] = 1'b1;
        d[3] = $urandom;
        serve(TO, 32'hCAFE_F00D);

        req_valid[1] = 1'b1;
        d[1] = $urandom;
        serve(2, $urandom);

        req_valid[3] = 1'b1;
        d[3] = 32'h0BAD_BEEF;
        @(negedge clk);
        chk("rw_ready", 64'(req_ready), 64'd8);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(negedge clk);
        chk("rw_start", 64'(mdl_start), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_wait");
        @(negedge clk);
        chk_reset("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        mdl_done   = 1'b1;
        mdl_result = 32'h1357_9BDF;
        @(negedge clk);
        chk("late_rsp", 64'(rsp_valid), 64'd0);
        chk("late_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        mdl_done = 1'b0;
        @(negedge clk);
        chk("late_rsp2", 64'(rsp_valid), 64'd0);
        chk("late_data", 64'(rsp_data), 64'd0);
        @(posedge clk); #1;
        last = NR - 1;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        d[0] = $urandom;
        d[3] = $urandom;
        serve(1, $urandom);
        serve(1, $urandom);

        repeat (150) begin
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    d[i] = $urandom;
                end
            if (req_valid == '0) begin
                mdl_done   = 1'($urandom_range(0, 1));
                mdl_result = $urandom;
                @(negedge clk);
                chk("idle_ready", 64'(req_ready), 64'd0);
                chk("idle_rsp", 64'(rsp_valid), 64'd0);
                chk("idle_busy", 64'(busy), 64'd0);
                @(posedge clk); #1;
                mdl_done = 1'b0;
            end else begin
                r = $urandom_range(0, 9);
                serve(r == 0 ? 0 : r == 1 ? TO : $urandom_range(1, 6), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
